// File: rtl/div_hilo_ctrl.sv
// HI/LO register file and sequencer wrapped around the restoring divider.
// Ports: clk, reset | start, funct, dataA, dataB, div_result ->
//   div_signal, div_dataA, div_dataB, stall, div_zero, hilo_out
module div_hilo_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [63:0] div_result,
  output logic [5:0]  div_signal,
  output logic [31:0] div_dataA,
  output logic [31:0] div_dataB,
  output logic        stall,
  output logic        div_zero,
  output logic [31:0] hilo_out
);

  localparam int CW = $clog2(DIV_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

  localparam logic [5:0] F_DIVU = 6'd27;
  localparam logic [5:0] F_MFHI = 6'd16;
  localparam logic [5:0] F_MFLO = 6'd18;
  localparam logic [5:0] F_MTHI = 6'd17;
  localparam logic [5:0] F_MTLO = 6'd19;

  localparam logic [5:0] CMD_IDLE = 6'd0;
  localparam logic [5:0] CMD_LOAD = 6'd27;
  localparam logic [5:0] CMD_OUT  = 6'd63;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    OUT
  } state_t;

  state_t        state;
  state_t        next;
  logic [CW-1:0] cnt;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [5:0]    sig_next;

  logic is_divu;
  logic is_mfhi;
  logic is_mflo;
  logic is_mthi;
  logic is_mtlo;
  logic hilo_op;
  logic take;
  logic b_zero;

  assign is_divu = funct == F_DIVU;
  assign is_mfhi = funct == F_MFHI;
  assign is_mflo = funct == F_MFLO;
  assign is_mthi = funct == F_MTHI;
  assign is_mtlo = funct == F_MTLO;
  assign hilo_op = is_divu | is_mfhi | is_mflo
                 | is_mthi | is_mtlo;
  assign b_zero  = dataB == 32'd0;

  // Instructions are only accepted in IDLE;
  // otherwise upstream holds them via stall.
  assign take  = start & (state == IDLE);
  assign stall = (state != IDLE) & start & hilo_op;

  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (take & is_divu & ~b_zero) next = LOAD;
      LOAD: next = RUN;
      RUN:  if (cnt == LAST) next = OUT;
      OUT:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Command is registered from the next state so
  // it tracks the state register edge for edge.
  always_comb begin
    sig_next = CMD_IDLE;
    if (next == LOAD) sig_next = CMD_LOAD;
    if (next == OUT)  sig_next = CMD_OUT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div_signal <= CMD_IDLE;
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      div_dataA  <= '0;
      div_dataB  <= '0;
      div_zero   <= 1'b0;
      hilo_out   <= '0;
    end else begin
      state      <= next;
      div_signal <= sig_next;
      if (state == LOAD) cnt <= '0;
      else if (state == RUN) cnt <= cnt + 1'b1;
      if (state == OUT) begin
        hi <= div_result[63:32];
        lo <= div_result[31:0];
      end
      if (take) begin
        unique case (1'b1)
          is_divu: begin
            if (b_zero) begin
              // Divide by zero bypasses the divider.
              hi       <= dataA;
              lo       <= 32'hFFFF_FFFF;
              div_zero <= 1'b1;
            end else begin
              div_dataA <= dataA;
              div_dataB <= dataB;
              div_zero  <= 1'b0;
            end
          end
          is_mthi: hi <= dataA;
          is_mtlo: lo <= dataA;
          is_mfhi: hilo_out <= hi;
          is_mflo: hilo_out <= lo;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl with a behavioural
// divider stand-in and hand-computed expected values.
module tb_div_hilo_ctrl;

  localparam logic [5:0] DIVU = 6'd27;
  localparam logic [5:0] MFHI = 6'd16;
  localparam logic [5:0] MFLO = 6'd18;
  localparam logic [5:0] MTHI = 6'd17;
  localparam logic [5:0] MTLO = 6'd19;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [63:0] div_result;
  logic [5:0]  div_signal;
  logic [31:0] div_dataA;
  logic [31:0] div_dataB;
  logic        stall;
  logic        div_zero;
  logic [31:0] hilo_out;

  int n_cmp = 0;
  int n_bad = 0;

  div_hilo_ctrl dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .funct(funct),
    .dataA(dataA),
    .dataB(dataB),
    .div_result(div_result),
    .div_signal(div_signal),
    .div_dataA(div_dataA),
    .div_dataB(div_dataB),
    .stall(stall),
    .div_zero(div_zero),
    .hilo_out(hilo_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    div_result = '0;
    if (div_dataB != 0)
      div_result = {div_dataA % div_dataB,
                    div_dataA / div_dataB};
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic op(input logic [5:0] f,
                    input logic [31:0] a,
                    input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    funct = f;
    dataA = a;
    dataB = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic rd(input logic [5:0] f,
                    output logic [31:0] v);
    op(f, 32'd0, 32'd0);
    @(negedge clk);
    v = hilo_out;
  endtask

  logic [31:0] v;
  int          stalls;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    funct = '0;
    dataA = '0;
    dataB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sig", 64'(div_signal), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_hilo", 64'(hilo_out), 64'd0);
    check("rst_da", 64'(div_dataA), 64'd0);
    reset = 1'b0;

    // 1: DIVU 100/7, command timing
    op(DIVU, 32'd100, 32'd7);
    @(negedge clk);
    check("t1_load", 64'(div_signal), 64'd27);
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) check("t1_run0", 64'(div_signal), 64'd0);
      if (k == 10) begin
        start = 1'b1;
        funct = 6'd32;
        #1 check("t1_nostall", 64'(stall), 64'd0);
        start = 1'b0;
      end
      if (k == 32) check("t1_run31", 64'(div_signal), 64'd0);
      if (k == 33) check("t1_out", 64'(div_signal), 64'd63);
    end
    @(posedge clk);
    @(negedge clk);
    check("t1_idle", 64'(div_signal), 64'd0);
    rd(MFHI, v);
    check("t1_hi", 64'(v), 64'd2);
    rd(MFLO, v);
    check("t1_lo", 64'(v), 64'd14);

    // 2: DIVU 200/9, MFLO held behind it
    op(DIVU, 32'd200, 32'd9);
    start = 1'b1;
    funct = MFLO;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
    end
    check("t2_stalls", 64'(stalls), 64'd34);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("t2_mflo", 64'(hilo_out), 64'd22);

    // 3: DIVU 55/0
    op(DIVU, 32'd55, 32'd0);
    @(negedge clk);
    check("t3_dz", 64'(div_zero), 64'd1);
    check("t3_sig", 64'(div_signal), 64'd0);
    @(negedge clk);
    check("t3_sig2", 64'(div_signal), 64'd0);
    rd(MFHI, v);
    check("t3_hi", 64'(v), 64'd55);
    rd(MFLO, v);
    check("t3_lo", 64'(v), 64'hFFFF_FFFF);

    // 4: MTHI/MTLO then read back
    op(MTHI, 32'hDEAD_BEEF, 32'd0);
    op(MTLO, 32'h1234_5678, 32'd0);
    @(negedge clk);
    start = 1'b1;
    funct = MFHI;
    #1 check("t4_stall", 64'(stall), 64'd0);
    start = 1'b0;
    rd(MFHI, v);
    check("t4_hi", 64'(v), 64'hDEAD_BEEF);
    rd(MFLO, v);
    check("t4_lo", 64'(v), 64'h1234_5678);
    check("t4_dz", 64'(div_zero), 64'd1);

    // 6: DIVU 9/3 then DIVU 10/4 held
    op(DIVU, 32'd9, 32'd3);
    start = 1'b1;
    funct = DIVU;
    dataA = 32'd10;
    dataB = 32'd4;
    @(negedge clk);
    check("t6_dz", 64'(div_zero), 64'd0);
    check("t6_da1", 64'(div_dataA), 64'd9);
    stalls = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
    end
    check("t6_stalls", 64'(stalls), 64'd34);
    check("t6_gap", 64'(div_signal), 64'd0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("t6_load2", 64'(div_signal), 64'd27);
    check("t6_da2", 64'(div_dataA), 64'd10);
    check("t6_db2", 64'(div_dataB), 64'd4);
    repeat (34) @(posedge clk);
    @(negedge clk);
    rd(MFHI, v);
    check("t6_hi", 64'(v), 64'd2);
    rd(MFLO, v);
    check("t6_lo", 64'(v), 64'd2);

    // 5: reset in RUN at cnt=10
    op(DIVU, 32'hFFFF_FFFF, 32'd1);
    repeat (11) @(posedge clk);
    #2 check("t5_busy", 64'(div_dataA), 64'hFFFF_FFFF);
    reset = 1'b1;
    #1 check("t5_sig", 64'(div_signal), 64'd0);
    check("t5_da", 64'(div_dataA), 64'd0);
    start = 1'b1;
    funct = MFLO;
    #1 check("t5_stall", 64'(stall), 64'd0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t5_idle", 64'(div_signal), 64'd0);
    rd(MFHI, v);
    check("t5_hi", 64'(v), 64'd0);
    rd(MFLO, v);
    check("t5_lo", 64'(v), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
